dvi_video_sequencer: RTL and testbench

//  Raster timing generator and period sequencer that drives the d/c/de inputs of three tmds_encode

---
 rtl/dvi_video_sequencer.sv | 114 +++++++++++
 tb/tb_dvi_video_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dvi_video_sequencer.sv
// Raster timing generator and period sequencer for a three-channel DVI (TMDS) link.
// Sync and data-enable are delayed two stages so they stay aligned with the fetched pixels.
module dvi_video_sequencer #(
   parameter int H_ACTIVE = 640,
   parameter int H_FRONT  = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BACK   = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FRONT  = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BACK   = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int W        = 12
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         enable,
   output logic         pix_req,
   output logic [W-1:0] x,
   output logic [W-1:0] y,
   output logic         frame_start,
   input  logic [23:0]  pix_rgb,
   output logic [7:0]   ch0_d,
   output logic [7:0]   ch1_d,
   output logic [7:0]   ch2_d,
   output logic [1:0]   ch0_c,
   output logic [1:0]   ch1_c,
   output logic [1:0]   ch2_c,
   output logic         de
);

   localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [W-1:0] H_LAST = W'(H_TOTAL - 1);
   localparam logic [W-1:0] V_LAST = W'(V_TOTAL - 1);

   // Boundaries are one bit wider than the counters so a period ending at 2**W still compares.
   localparam logic [W:0] H_ACT_END  = (W+1)'(H_ACTIVE);
   localparam logic [W:0] H_SYNC_BEG = (W+1)'(H_ACTIVE + H_FRONT);
   localparam logic [W:0] H_SYNC_END = (W+1)'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [W:0] V_ACT_END  = (W+1)'(V_ACTIVE);
   localparam logic [W:0] V_SYNC_BEG = (W+1)'(V_ACTIVE + V_FRONT);
   localparam logic [W:0] V_SYNC_END = (W+1)'(V_ACTIVE + V_FRONT + V_SYNC);

   logic [W-1:0] h;
   logic [W-1:0] v;
   logic         active;
   logic         hs;
   logic         vs;
   logic         active_s1;
   logic         hs_s1;
   logic         vs_s1;

   // Disabling the raster parks it at the origin so re-enabling always starts a fresh frame.
   always_ff @(posedge clock) begin
      if (reset || !enable) begin
         h <= '0;
         v <= '0;
      end else if (h == H_LAST) begin
         h <= '0;
         v <= (v == V_LAST) ? '0 : v + W'(1);
      end else begin
         h <= h + W'(1);
      end
   end

   always_comb begin
      active = ({1'b0, h} < H_ACT_END) && ({1'b0, v} < V_ACT_END);
      hs     = ({1'b0, h} >= H_SYNC_BEG) && ({1'b0, h} < H_SYNC_END);
      vs     = ({1'b0, v} >= V_SYNC_BEG) && ({1'b0, v} < V_SYNC_END);
   end

   // Fetch contract: pix_req/x/y name one pixel this cycle and the source must present it on
   // pix_rgb in the very next cycle; there is no ready, the source can never stall the raster.
   assign pix_req     = active & enable;
   assign x           = h;
   assign y           = v;
   assign frame_start = enable && (h == '0) && (v == '0);

   always_ff @(posedge clock) begin
      if (reset) begin
         active_s1 <= 1'b0;
         hs_s1     <= 1'b0;
         vs_s1     <= 1'b0;
      end else begin
         active_s1 <= pix_req;
         hs_s1     <= hs & enable;
         vs_s1     <= vs & enable;
      end
   end

   // Stage 2 meets the pixel returned for the stage-1 request.
   always_ff @(posedge clock) begin
      if (reset) begin
         de    <= 1'b0;
         ch0_d <= 8'd0;
         ch1_d <= 8'd0;
         ch2_d <= 8'd0;
         ch0_c <= {~VS_POL, ~HS_POL};
      end else begin
         de    <= active_s1;
         ch0_d <= active_s1 ? pix_rgb[7:0]   : 8'd0;
         ch1_d <= active_s1 ? pix_rgb[15:8]  : 8'd0;
         ch2_d <= active_s1 ? pix_rgb[23:16] : 8'd0;
         ch0_c <= {vs_s1 ^ ~VS_POL, hs_s1 ^ ~HS_POL};
      end
   end

   assign ch1_c = 2'b00;
   assign ch2_c = 2'b00;

endmodule

// File: tb/tb_dvi_video_sequencer.sv
// Bench for dvi_video_sequencer: default horizontal timing with a shortened frame height so
// whole frames, wraps and mid-sync resets fit in a short run.
module tb_dvi_video_sequencer;

   localparam int H_A = 640, H_F = 16, H_S = 96, H_B = 48;
   localparam int V_A = 3, V_F = 1, V_S = 2, V_B = 1;
   localparam int H_T = H_A + H_F + H_S + H_B;
   localparam int V_T = V_A + V_F + V_S + V_B;
   localparam int FRAME = H_T * V_T;
   localparam int W = 12;
   localparam bit HS_P = 1'b0;
   localparam bit VS_P = 1'b0;

   // ---------------- clock / reset / signals ----------------
   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         enable = 1'b1;
   logic [23:0]  pix_rgb = 24'h0;
   logic         pix_req, frame_start, de;
   logic [W-1:0] x, y;
   logic [7:0]   ch0_d, ch1_d, ch2_d;
   logic [1:0]   ch0_c, ch1_c, ch2_c;

   always #5 clock = ~clock;

   dvi_video_sequencer #(
      .H_ACTIVE(H_A), .H_FRONT(H_F), .H_SYNC(H_S), .H_BACK(H_B),
      .V_ACTIVE(V_A), .V_FRONT(V_F), .V_SYNC(V_S), .V_BACK(V_B),
      .HS_POL(HS_P), .VS_POL(VS_P), .W(W)
   ) dut (
      .clock(clock), .reset(reset), .enable(enable),
      .pix_req(pix_req), .x(x), .y(y), .frame_start(frame_start),
      .pix_rgb(pix_rgb),
      .ch0_d(ch0_d), .ch1_d(ch1_d), .ch2_d(ch2_d),
      .ch0_c(ch0_c), .ch1_c(ch1_c), .ch2_c(ch2_c),
      .de(de)
   );

   // ---------------- reference model / scoreboard ----------------
   typedef struct {
      bit          rst;
      bit          en;
      int          pos;
      logic [23:0] rgb;
   } hist_t;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          pos = 0;       // cycle offset within the frame the counters should hold
   bit          pos_known = 1'b0;
   bit          have_prev = 1'b0;
   hist_t       prev;
   logic [26:0] exp_q[$];      // {de, ch0_c, rgb} expected on the next cycle

   function automatic bit f_active(int p);
      return ((p % H_T) < H_A) && ((p / H_T) < V_A);
   endfunction

   function automatic bit f_hs(int p);
      int h;
      h = p % H_T;
      return (h >= H_A + H_F) && (h < H_A + H_F + H_S);
   endfunction

   function automatic bit f_vs(int p);
      int v;
      v = p / H_T;
      return (v >= V_A + V_F) && (v < V_A + V_F + V_S);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cycle %0d: got 0x%0h, want 0x%0h", name, cyc, act, exp);
      end
   endtask

   // ---------------- driver ----------------
   task automatic tick(input bit rst, input bit en, input logic [23:0] rgb);
      logic [26:0] e;
      hist_t       cur;
      bit          valid, e_de, e_hs, e_vs;
      logic [1:0]  e_c0;
      @(posedge clock);
      #1;
      reset   = rst;
      enable  = en;
      pix_rgb = rgb;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("de", de, e[26]);
         check("ch0_c", ch0_c, e[25:24]);
         check("ch1_c", ch1_c, 2'b00);
         check("ch2_c", ch2_c, 2'b00);
         check("ch0_d", ch0_d, e[7:0]);
         check("ch1_d", ch1_d, e[15:8]);
         check("ch2_d", ch2_d, e[23:16]);
      end
      if (pos_known) begin
         check("pix_req", pix_req, en && f_active(pos));
         check("frame_start", frame_start, en && (pos == 0));
         check("x", x, pos % H_T);
         check("y", y, pos / H_T);
      end
      cur   = '{rst, en, pos, rgb};
      valid = !rst && have_prev && !prev.rst && prev.en;
      e_de  = valid && f_active(prev.pos);
      e_hs  = valid && f_hs(prev.pos);
      e_vs  = valid && f_vs(prev.pos);
      e_c0  = {e_vs ? VS_P : ~VS_P, e_hs ? HS_P : ~HS_P};
      exp_q.push_back({e_de, e_c0, e_de ? rgb : 24'h0});
      prev      = cur;
      have_prev = 1'b1;
      if (rst) pos_known = 1'b1;
      pos = (rst || !en) ? 0 : (pos + 1) % FRAME;
      cyc++;
   endtask

   // ---------------- test vectors ----------------
   typedef struct {
      int         h;
      int         v;
      int         f;
      bit         req;
      bit         fs;
      bit         de;
      logic [1:0] c0;
   } vec_t;

   vec_t vecs[$];

   initial begin
      int k;
      int target;
      vec_t t;

      // Registered expectations (de, c0) describe the output seen in the same cycle as (h,v),
      // i.e. the raster state two pixels earlier.
      vecs.push_back('{0,   0, 0, 1, 1, 0, 2'b11});
      vecs.push_back('{1,   0, 0, 1, 0, 0, 2'b11});
      vecs.push_back('{2,   0, 0, 1, 0, 1, 2'b11});
      vecs.push_back('{639, 0, 0, 1, 0, 1, 2'b11});
      vecs.push_back('{640, 0, 0, 0, 0, 1, 2'b11});
      vecs.push_back('{641, 0, 0, 0, 0, 1, 2'b11});
      vecs.push_back('{642, 0, 0, 0, 0, 0, 2'b11});
      vecs.push_back('{657, 0, 0, 0, 0, 0, 2'b11});
      vecs.push_back('{658, 0, 0, 0, 0, 0, 2'b10});
      vecs.push_back('{753, 0, 0, 0, 0, 0, 2'b10});
      vecs.push_back('{754, 0, 0, 0, 0, 0, 2'b11});
      vecs.push_back('{799, 0, 0, 0, 0, 0, 2'b11});
      vecs.push_back('{0,   1, 0, 1, 0, 0, 2'b11});
      vecs.push_back('{2,   1, 0, 1, 0, 1, 2'b11});
      vecs.push_back('{0,   3, 0, 0, 0, 0, 2'b11});
      vecs.push_back('{1,   4, 0, 0, 0, 0, 2'b11});
      vecs.push_back('{2,   4, 0, 0, 0, 0, 2'b01});
      vecs.push_back('{658, 4, 0, 0, 0, 0, 2'b00});
      vecs.push_back('{754, 5, 0, 0, 0, 0, 2'b01});
      vecs.push_back('{1,   6, 0, 0, 0, 0, 2'b01});
      vecs.push_back('{2,   6, 0, 0, 0, 0, 2'b11});
      vecs.push_back('{0,   0, 1, 1, 1, 0, 2'b11});
      vecs.push_back('{2,   0, 1, 1, 0, 1, 2'b11});

      // Reset held three cycles with enable high.
      repeat (3) tick(1'b1, 1'b1, 24'h0);
      check("rst_de", de, 1'b0);
      check("rst_ch0_c", ch0_c, 2'b11);
      check("rst_d", {ch2_d, ch1_d, ch0_d}, 24'h0);

      // Table walk over one frame plus the wrap; the source returns a fixed colour.
      k = 0;
      for (int i = 0; i < vecs.size(); i++) begin
         t = vecs[i];
         target = t.f * FRAME + t.v * H_T + t.h;
         while (k < target) begin
            tick(1'b0, 1'b1, 24'hA1B2C3);
            k++;
         end
         tick(1'b0, 1'b1, 24'hA1B2C3);
         k++;
         check($sformatf("tbl%0d_req", i), pix_req, t.req);
         check($sformatf("tbl%0d_fs", i), frame_start, t.fs);
         check($sformatf("tbl%0d_x", i), x, t.h);
         check($sformatf("tbl%0d_y", i), y, t.v);
         check($sformatf("tbl%0d_de", i), de, t.de);
         check($sformatf("tbl%0d_c0", i), ch0_c, t.c0);
         check($sformatf("tbl%0d_d", i), {ch2_d, ch1_d, ch0_d}, t.de ? 24'hA1B2C3 : 24'h0);
      end

      // Drop enable at (100,2): counters park, de falls two cycles later, restart at origin.
      target = FRAME + 2 * H_T + 100;
      while (k < target) begin
         tick(1'b0, 1'b1, 24'($urandom()));
         k++;
      end
      tick(1'b0, 1'b0, 24'($urandom()));
      check("dis_req", pix_req, 1'b0);
      check("dis_fs", frame_start, 1'b0);
      tick(1'b0, 1'b0, 24'($urandom()));
      check("dis_x", x, 0);
      check("dis_y", y, 0);
      check("dis_de_lag", de, 1'b1);
      tick(1'b0, 1'b1, 24'($urandom()));
      check("dis_de_off", de, 1'b0);
      check("ena_req", pix_req, 1'b1);
      check("ena_fs", frame_start, 1'b1);
      check("ena_xy", {x, y}, 24'h0);

      // Reset in the middle of hsync on a vsync line, then one full frame cycle-exact.
      repeat (4 * H_T + 700 - 1) tick(1'b0, 1'b1, 24'($urandom()));
      tick(1'b1, 1'b1, 24'($urandom()));
      check("midsync_c0", ch0_c, 2'b00);
      tick(1'b0, 1'b1, 24'($urandom()));
      check("midsync_rst_de", de, 1'b0);
      check("midsync_rst_c0", ch0_c, 2'b11);
      check("midsync_rst_d", {ch2_d, ch1_d, ch0_d}, 24'h0);
      check("midsync_req", pix_req, 1'b1);
      check("midsync_fs", frame_start, 1'b1);
      repeat (FRAME) tick(1'b0, 1'b1, 24'($urandom()));

      // Random enable drops and occasional resets against the model.
      repeat (3 * FRAME) begin
         tick($urandom_range(0, 1999) < 2, $urandom_range(0, 999) >= 3, 24'($urandom()));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
